// File: rtl/ay_bus_sequencer.sv
// ay_bus_sequencer: queues PSG register writes and drives them as latch/write/gap bus cycles on bdir/bc1/da.
module ay_bus_sequencer #(
  parameter logic [3:0] UPPER_ADDRESS_MASK = 4'b0000,
  parameter int         FIFO_DEPTH         = 4,
  parameter int         GAP_CYCLES         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_addr,
  input  logic [7:0]                    in_data,
  output logic                          bdir,
  output logic                          bc1,
  output logic [7:0]                    da,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, LATCH, WRITE, GAP} state_t;
  state_t state_q, state_d;
  logic [11:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic [3:0] addr_q, shadow_addr_q, gap_q, gap_d, head_addr;
  logic [7:0] data_q, da_q, da_d, head_data;
  logic shadow_valid_q, bdir_q, bc1_q, bdir_d, bc1_d;
  logic push, pop, decide, skip;
  assign {head_addr, head_data} = mem_q[rd_q];
  assign in_ready   = level_q != LW'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign decide     = state_q == IDLE || (state_q == GAP && gap_q == 4'd0);
  assign pop        = decide && level_q != '0;
  assign skip       = shadow_valid_q && head_addr == shadow_addr_q;
  assign busy       = level_q != '0 || state_q != IDLE;
  assign fifo_level = level_q;
  assign bdir       = bdir_q;
  assign bc1        = bc1_q;
  assign da         = da_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gap_q          <= '0;
      bdir_q         <= 1'b0;
      bc1_q          <= 1'b0;
      da_q           <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      level_q        <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      shadow_addr_q  <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      bdir_q  <= bdir_d;
      bc1_q   <= bc1_d;
      da_q    <= da_d;
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_q + LW'(push) - LW'(pop);
      if (pop) {addr_q, data_q} <= mem_q[rd_q];
      if (state_q == WRITE) begin
        shadow_addr_q  <= addr_q;
        shadow_valid_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_addr, in_data};
  always_comb begin
    state_d = state_q;
    if (state_q == LATCH) state_d = WRITE;
    else if (state_q == WRITE) state_d = GAP;
    else if (decide) state_d = !pop ? IDLE : skip ? WRITE : LATCH;
    gap_d = state_q == WRITE ? 4'(GAP_CYCLES - 1) :
            (state_q == GAP && gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    bdir_d = state_d == LATCH || state_d == WRITE;
    bc1_d  = state_d == LATCH;
    da_d   = state_d == LATCH ? {UPPER_ADDRESS_MASK, head_addr} :
             state_d == WRITE ? (state_q == LATCH ? data_q : head_data) : da_q;
  end
endmodule

// File: tb/tb_ay_bus_sequencer.sv
// tb_ay_bus_sequencer: vector table, directed corner cases and a randomized scoreboard for ay_bus_sequencer.
module tb_ay_bus_sequencer;
  localparam int G = 1;
  localparam int D = 4;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [3:0] in_addr = 0;
  logic [7:0] in_data = 0;
  logic in_ready, bdir, bc1, busy;
  logic [7:0] da;
  logic [2:0] fifo_level;
  logic v2 = 0;
  logic [3:0] a2 = 0;
  logic [7:0] d2 = 0;
  logic r2, b2, c2, bsy2;
  logic [7:0] da2;
  logic [1:0] l2;
  int n_cmp = 0, n_bad = 0, edge_n = 0;
  ay_bus_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .bdir(bdir), .bc1(bc1), .da(da), .busy(busy), .fifo_level(fifo_level)
  );
  ay_bus_sequencer #(.UPPER_ADDRESS_MASK(4'b1010), .FIFO_DEPTH(2), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .in_addr(a2),
    .in_data(d2), .bdir(b2), .bc1(c2), .da(da2), .busy(bsy2), .fifo_level(l2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: accepted requests must reach the bus in order, each starting at the
  // earliest cycle allowed by its arrival time and the previous write's gap.
  typedef struct { logic [3:0] a; logic [7:0] d; int e; } req_t;
  req_t q[$];
  req_t cur, push_r;
  logic mon_en = 0, push_s = 0, rst_s = 1, last_v = 0, in_latch = 0;
  logic [3:0] last_a = 0;
  logic [7:0] last_da = 0;
  logic [1:0] bus;
  int last_w = -1000, exp_e;
  task automatic write_done();
    last_v = 1; last_a = cur.a; last_da = cur.d; last_w = edge_n;
  endtask
  always @(negedge clk) if (mon_en) begin
    if (rst_s) begin
      q.delete(); last_v = 0; last_da = 0; last_w = -1000; in_latch = 0;
    end else if (push_s) q.push_back(push_r);
    bus = {bdir, bc1};
    if (in_latch) begin
      check("after_latch_bus", bus, 2'b10);
      check("write_da", da, cur.d);
      write_done();
      in_latch = 0;
    end else if (bdir) begin
      if (q.size() == 0) check("spurious_bus", bus, 2'b00);
      else begin
        cur = q.pop_front();
        exp_e = (cur.e + 1 > last_w + G + 1) ? cur.e + 1 : last_w + G + 1;
        check("start_edge", edge_n, exp_e);
        check("latch_needed", bc1, !(last_v && last_a == cur.a));
        if (bc1) begin
          check("latch_da", da, {4'h0, cur.a});
          in_latch = 1;
        end else begin
          check("skip_da", da, cur.d);
          write_done();
        end
      end
    end else begin
      check("idle_bus", bus, 2'b00);
      check("hold_da", da, last_da);
    end
    check("level", fifo_level, q.size());
    check("ready", in_ready, q.size() != D);
    push_s = in_valid && in_ready && !reset;
    push_r = '{a: in_addr, d: in_data, e: edge_n + 1};
    rst_s  = reset;
  end
  typedef struct { logic v; logic [3:0] a; logic [7:0] d; logic b, c; logic [7:0] x; logic [2:0] l; logic r, bs; } vec_t;
  vec_t vecs[$];
  task automatic add(input logic v, input logic [3:0] a, input logic [7:0] d, input logic b, input logic c,
                     input logic [7:0] x, input logic [2:0] l, input logic r, input logic bs);
    vecs.push_back('{v, a, d, b, c, x, l, r, bs});
  endtask
  int k;
  logic acc, found, saw_full;
  logic [1:0] eb;
  logic [7:0] ed;
  initial begin
    add(1, 7, 8'h38, 0, 0, 8'h00, 1, 1, 1);
    add(0, 0, 8'h00, 1, 1, 8'h07, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h38, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h38, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h38, 0, 1, 0);
    add(1, 8, 8'h0F, 0, 0, 8'h38, 1, 1, 1);
    add(1, 8, 8'h0A, 1, 1, 8'h08, 1, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h0F, 1, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h0F, 1, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h0A, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h0A, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h0A, 0, 1, 0);
    add(1, 9, 8'h55, 0, 0, 8'h0A, 1, 1, 1);
    add(0, 0, 8'h00, 1, 1, 8'h09, 0, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h55, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h55, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h55, 0, 1, 0);
    tick(); tick();
    mon_en = 1;
    in_valid = 1; in_addr = 3; in_data = 8'h99;
    tick();
    check("reset_state", {bdir, bc1, da, fifo_level, busy, in_ready}, {2'b00, 8'h00, 3'd0, 1'b0, 1'b1});
    in_valid = 0; reset = 0;
    tick();
    check("no_accept_in_reset", {fifo_level, busy}, 4'b0000);
    foreach (vecs[i]) begin
      in_valid = vecs[i].v; in_addr = vecs[i].a; in_data = vecs[i].d;
      tick();
      check($sformatf("vec%0d", i), {bdir, bc1, da, fifo_level, in_ready, busy},
            {vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].l, vecs[i].r, vecs[i].bs});
    end
    in_valid = 0;
    k = 0; found = 0; saw_full = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      in_valid = k < 6; in_addr = 4'(k + 1); in_data = 8'(8'hA0 + k);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      if (fifo_level == 3'd4) begin
        saw_full = 1;
        check("full_not_ready", in_ready, 0);
      end
      if (bdir && !bc1 && fifo_level == 3'd3 && k == 6) found = 1;
    end
    in_valid = 0;
    check("write_with_3_queued", found, 1);
    check("reached_full", saw_full, 1);
    reset = 1;
    tick();
    check("mid_write_reset", {bdir, bc1, da, fifo_level, busy, in_ready}, {2'b00, 8'h00, 3'd0, 1'b0, 1'b1});
    reset = 0;
    in_valid = 1; in_addr = 2; in_data = 8'h5A;
    tick();
    in_valid = 0;
    for (int t = 0; t < 10 && !bdir; t++) tick();
    check("latch_after_reset", {bdir, bc1}, 2'b11);
    for (int t = 1; t <= 11; t++) begin
      v2 = t <= 2; a2 = 13; d2 = t == 1 ? 8'h77 : 8'h78;
      tick();
      eb = t == 2 ? 2'b11 : (t == 3 || t == 7) ? 2'b10 : 2'b00;
      ed = t == 1 ? 8'h00 : t == 2 ? 8'hAD : t < 7 ? 8'h77 : 8'h78;
      check($sformatf("mask_seq%0d", t), {b2, c2, da2}, {eb, ed});
    end
    check("mask_idle_busy", bsy2, 0);
    for (int i = 0; i < 2500; i++) begin
      reset = $urandom_range(0, 199) == 0;
      in_valid = $urandom_range(0, 9) < (((i / 400) % 2) != 0 ? 9 : 3);
      in_addr = 4'($urandom_range(0, 3));
      in_data = 8'($urandom);
      tick();
    end
    reset = 0; in_valid = 0;
    for (int t = 0; t < 100 && busy; t++) tick();
    tick();
    check("drain_idle", {busy, fifo_level}, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ay_bus_sequencer.md
AY_BUS_SEQUENCER -- requirements
Module: ay_bus_sequencer

Interface
REQ-001 SHALL have parameter UPPER_ADDRESS_MASK, default 4'b0000: value driven on da[7:4] during latch phase.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: request FIFO entries, power of two, range 2..16.
REQ-003 SHALL have parameter GAP_CYCLES, default 1: inactive bus cycles after each write, range 1..15.
REQ-004 SHALL have port clk input 1: clock, all state updates on rising edge.
REQ-005 SHALL have port reset input 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid input 1: request present.
REQ-007 SHALL have port in_ready output 1: FIFO can accept a request.
REQ-008 SHALL have port in_addr input 4: target PSG register R0..R15.
REQ-009 SHALL have port in_data input 8: value for target register.
REQ-010 SHALL have port bdir output 1: PSG bus direction line.
REQ-011 SHALL have port bc1 output 1: PSG bus control line.
REQ-012 SHALL have port da output 8: PSG data/address bus.
REQ-013 SHALL have port busy output 1: high when FIFO non-empty or state not IDLE.
REQ-014 SHALL have port fifo_level output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready; in_ready = (fifo_level != FIFO_DEPTH), independent of in_valid and of a same-cycle pop.
REQ-016 SHALL store requests in FIFO order, no drops and no duplication; in_valid while full is ignored.
REQ-017 SHALL implement states IDLE, LATCH, WRITE, GAP; bdir/bc1/da are registered and correspond to the current state.
REQ-018 IDLE: bdir=0, bc1=0, da holds last value written in WRITE (0 after reset).
REQ-019 LATCH: bdir=1, bc1=1, da={UPPER_ADDRESS_MASK, addr}; exactly one cycle; next state WRITE.
REQ-020 WRITE: bdir=1, bc1=0, da=data; exactly one cycle; sets shadow_addr=addr, shadow_valid=1; next state GAP.
REQ-021 GAP: bdir=0, bc1=0, da holds written data; lasts GAP_CYCLES cycles, counted by an internal down-counter.
REQ-022 Decision point is IDLE or the final GAP cycle: if FIFO non-empty, pop head that cycle and go to LATCH, or to WRITE directly if shadow_valid && head addr == shadow_addr; else go/stay IDLE.
REQ-023 A push into an empty FIFO on edge t SHALL make the head visible at the decision point in cycle t+1, not earlier (no bypass).
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 Sustained throughput SHALL be 2+GAP_CYCLES cycles per write with a latch, 1+GAP_CYCLES when the latch is skipped.
REQ-026 bdir=1 with bc1=1 SHALL occur only in LATCH; bdir=0 with bc1=1 (read) SHALL never be driven.

Reset
REQ-027 Reset SHALL force state IDLE, FIFO empty (fifo_level=0), shadow_valid=0, gap counter 0, bdir=0, bc1=0, da=0, busy=0, in_ready=1 on the next edge.
REQ-028 Reset asserted mid-sequence (LATCH/WRITE/GAP) SHALL abort the sequence and discard all queued requests; no bus activity until a new request after reset deasserts.
REQ-029 A request presented in the same cycle as reset SHALL not be accepted.

Verification
REQ-030 Single write: after reset push (addr=7, data=0x38) at edge t -> LATCH at t+2 with da=0x07, bdir=1, bc1=1; WRITE at t+3 with da=0x38, bc1=0; GAP t+4; IDLE t+5, busy=0.
REQ-031 Latch skip: push (addr=8,data=0x0F) then (addr=8,data=0x0A) -> second write goes GAP->WRITE, no LATCH; da=0x0A; 5 cycles total between first LATCH and second GAP end with GAP_CYCLES=1.
REQ-032 Back-pressure: hold in_valid for 6 distinct requests while sink runs, FIFO_DEPTH=4 -> in_ready low when level=4; all 6 emitted in order, none lost.
REQ-033 Simultaneous push/pop at level=4: in_ready=0, push ignored, level 3 after edge; at level=2 push+pop keeps level 2.
REQ-034 Reset mid-WRITE with 3 queued -> next edge bdir=0, bc1=0, da=0, fifo_level=0; subsequent write to prior shadow address performs LATCH (shadow invalid).
REQ-035 Mask parameter: UPPER_ADDRESS_MASK=4'b1010, addr=13 -> LATCH da=0xAD.
